// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dmem_arb_pkg: shared types and default sizes for dmem_arbiter  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package dmem_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int DEF_ADDR_W   = 12;
  localparam int DEF_LEN_W    = 4;
  localparam int DEF_WAIT_MAX = 8;

endpackage
`default_nettype wire

// File: rtl/dmem_burst_ctr.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dmem_burst_ctr: host burst address and remaining-beat counter  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module dmem_burst_ctr
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_left;

  // Beat 0 is issued straight from the request, so the counter starts one beat ahead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr <= '0;
      r_left <= '0;
    end else if (load) begin
      r_addr <= load_addr + ADDR_W'(1);
      r_left <= load_len;
    end else if (step) begin
      r_addr <= r_addr + ADDR_W'(1);
      r_left <= r_left - LEN_W'(1);
    end
  end

  assign addr = r_addr;
  assign last = (r_left == LEN_W'(1));

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | dmem_arbiter: core / host-burst arbiter for the data memory    |
// | Optional statistics counters: define DMEM_ARB_STATS_EN         |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int WAIT_MAX = DEF_WAIT_MAX
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [31:0]       c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [31:0]       c_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [LEN_W-1:0]  h_len,
  output logic              h_gnt,
  output logic              h_beat,
  input  logic [31:0]       h_wdata,
  output logic              h_rvalid,
  output logic [31:0]       h_rdata,
  output logic              h_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       stat_core_wait,
  output logic [31:0]       stat_host_beats
);

  localparam int              WAIT_W     = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic              r_h_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_c_rvalid;
  logic              r_h_rvalid;
  logic [31:0]       r_c_rdata;
  logic [31:0]       r_h_rdata;
  logic              w_starved;
  logic              w_ctr_last;
  logic              w_ctr_step;
  logic [ADDR_W-1:0] w_ctr_addr;
  logic [ADDR_W-1:0] w_host_addr;
  logic              w_host_we;

  assign w_starved  = h_req && (r_wait_cnt == WAIT_LIMIT);
  assign w_ctr_step = h_beat && (r_state == ARB_BURST);

  dmem_burst_ctr #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_burst_ctr (
    .clk       (clk),
    .reset     (reset),
    .load      (h_gnt),
    .load_addr (h_addr),
    .load_len  (h_len),
    .step      (w_ctr_step),
    .addr      (w_ctr_addr),
    .last      (w_ctr_last)
  );

  // Grants are suppressed while reset is held so an aborted burst cannot write.
  always_comb begin
    w_state_nxt = r_state;
    c_gnt       = 1'b0;
    h_gnt       = 1'b0;
    h_beat      = 1'b0;
    h_done      = 1'b0;
    w_host_addr = w_ctr_addr;
    w_host_we   = r_h_we;
    if (reset) begin
      case (r_state)
        ARB_IDLE: begin
          if (c_req && !w_starved) begin
            c_gnt = 1'b1;
          end else if (h_req) begin
            h_gnt       = 1'b1;
            h_beat      = 1'b1;
            w_host_addr = h_addr;
            w_host_we   = h_we;
            if (h_len == '0) h_done = 1'b1;
            else             w_state_nxt = ARB_BURST;
          end
        end
        ARB_BURST: begin
          h_beat = 1'b1;
          if (w_ctr_last) begin
            h_done      = 1'b1;
            w_state_nxt = ARB_IDLE;
          end
        end
        default: w_state_nxt = ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_addr  = r_mem_addr;
    mem_wdata = r_mem_wdata;
    mem_we    = 1'b0;
    if (c_gnt) begin
      mem_addr  = c_addr;
      mem_wdata = c_wdata;
      mem_we    = c_we;
    end else if (h_beat) begin
      mem_addr  = w_host_addr;
      mem_wdata = h_wdata;
      mem_we    = w_host_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ARB_IDLE;
      r_wait_cnt  <= '0;
      r_h_we      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_c_rvalid  <= 1'b0;
      r_h_rvalid  <= 1'b0;
      r_c_rdata   <= '0;
      r_h_rdata   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (h_gnt) begin
        r_wait_cnt <= '0;
        r_h_we     <= h_we;
      end else if ((r_state == ARB_IDLE) && h_req && (r_wait_cnt != WAIT_LIMIT)) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end
      if (c_gnt || h_beat) begin
        r_mem_addr  <= mem_addr;
        r_mem_wdata <= mem_wdata;
      end
      r_c_rvalid <= c_gnt && !c_we;
      r_h_rvalid <= h_beat && !w_host_we;
      if (c_gnt && !c_we)      r_c_rdata <= mem_rdata;
      if (h_beat && !w_host_we) r_h_rdata <= mem_rdata;
    end
  end

  assign c_rvalid = r_c_rvalid;
  assign c_rdata  = r_c_rdata;
  assign h_rvalid = r_h_rvalid;
  assign h_rdata  = r_h_rdata;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] r_stat_core_wait;
  logic [31:0] r_stat_host_beats;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stat_core_wait  <= '0;
      r_stat_host_beats <= '0;
    end else begin
      if (c_req && !c_gnt) r_stat_core_wait  <= r_stat_core_wait + 32'd1;
      if (h_beat)          r_stat_host_beats <= r_stat_host_beats + 32'd1;
    end
  end

  assign stat_core_wait  = r_stat_core_wait;
  assign stat_host_beats = r_stat_host_beats;
`else
  assign stat_core_wait  = '0;
  assign stat_host_beats = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | tb_dmem_arbiter: directed and randomized checks of dmem_arbiter|
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module tb_dmem_arbiter;

  localparam int ADDR_W   = 12;
  localparam int LEN_W    = 4;
  localparam int WAIT_MAX = 8;
  localparam int DEPTH    = 4096;

  logic              clk = 1'b0;
  logic              reset;
  logic              c_req, c_we, c_gnt, c_rvalid;
  logic [ADDR_W-1:0] c_addr;
  logic [31:0]       c_wdata, c_rdata;
  logic              h_req, h_we, h_gnt, h_beat, h_rvalid, h_done;
  logic [ADDR_W-1:0] h_addr;
  logic [LEN_W-1:0]  h_len;
  logic [31:0]       h_wdata, h_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata, mem_rdata;
  logic [31:0]       stat_core_wait, stat_host_beats;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_len(h_len),
    .h_gnt(h_gnt), .h_beat(h_beat), .h_wdata(h_wdata),
    .h_rvalid(h_rvalid), .h_rdata(h_rdata), .h_done(h_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stat_core_wait(stat_core_wait), .stat_host_beats(stat_host_beats)
  );

  function automatic logic [31:0] init_pat(int a);
    return 32'h9E3779B9 * 32'(a + 1);
  endfunction

  // Environment memory: unwritten words read back a fixed address pattern.
  logic [31:0] env_mem [DEPTH];
  bit          env_wr  [DEPTH];
  assign mem_rdata = env_wr[mem_addr] ? env_mem[mem_addr] : init_pat(int'(mem_addr));
  always @(posedge clk) begin
    if (mem_we) begin
      env_mem[mem_addr] <= mem_wdata;
      env_wr[mem_addr]  <= 1'b1;
    end
  end

  logic [31:0] ref_mem [DEPTH];

  function automatic logic [31:0] stat_exp(int v);
`ifdef DMEM_ARB_STATS_EN
    return 32'(v);
`else
    return 32'd0 & 32'(v);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctl"}, 32'({c_gnt, h_gnt, h_beat, h_done, c_rvalid, h_rvalid, mem_we}), 32'd0);
    chk({tag, "_maddr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
    chk({tag, "_crdata"}, c_rdata, 32'd0);
    chk({tag, "_hrdata"}, h_rdata, 32'd0);
    chk({tag, "_stat_cw"}, stat_core_wait, 32'd0);
    chk({tag, "_stat_hb"}, stat_host_beats, 32'd0);
  endtask

  initial begin
    int          exp_cw, exp_hb, we_cycles;
    logic [11:0] a;
    int          m_left, m_wait;
    logic [11:0] m_addr, last_a, ea;
    logic        m_we, ecg, ehg, ehb, ehd, ewe, e_c_rv, e_h_rv;
    logic [31:0] ewd, exp_c_rdata, exp_h_rdata;

    for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_pat(i);
    exp_cw = 0; exp_hb = 0;
    reset = 1'b0; c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
    h_req = 0; h_we = 0; h_addr = '0; h_len = '0; h_wdata = '0;
    step(); step();
    chk_all_zero("reset");

    // Core write then read of 0x010
    reset = 1'b1; c_req = 1; c_we = 1; c_addr = 12'h010; c_wdata = 32'hDEADBEEF; #1;
    chk("core_wr_gnt", 32'(c_gnt), 32'd1);
    chk("core_wr_we", 32'(mem_we), 32'd1);
    chk("core_wr_addr", 32'(mem_addr), 32'h010);
    ref_mem[12'h010] = 32'hDEADBEEF;
    step(); c_we = 0; #1;
    chk("core_rd_gnt", 32'(c_gnt), 32'd1);
    chk("core_wr_no_rvalid", 32'(c_rvalid), 32'd0);
    step(); c_req = 0; #1;
    chk("core_rd_rvalid", 32'(c_rvalid), 32'd1);
    chk("core_rd_data", c_rdata, 32'hDEADBEEF);
    chk("idle_addr_hold", 32'(mem_addr), 32'h010);
    chk("idle_no_we", 32'(mem_we), 32'd0);

    // Host write burst wrapping past the top of memory
    h_req = 1; h_we = 1; h_addr = 12'hFFE; h_len = 4'd3; we_cycles = 0;
    for (int i = 0; i < 4; i++) begin
      a = 12'hFFE + 12'(i);
      h_wdata = 32'hA5000000 + 32'(i); #1;
      chk("hw_beat", 32'(h_beat), 32'd1);
      chk("hw_addr", 32'(mem_addr), 32'(a));
      chk("hw_gnt", 32'(h_gnt), 32'(i == 0));
      chk("hw_done", 32'(h_done), 32'(i == 3));
      if (mem_we) we_cycles++;
      ref_mem[a] = h_wdata; exp_hb++;
      step(); h_req = 0;
    end
    #1;
    if (mem_we) we_cycles++;
    chk("hw_end_beat", 32'(h_beat), 32'd0);
    chk("hw_we_cycles", 32'(we_cycles), 32'd4);
    chk("hw_wrap_mem", env_mem[12'h000], 32'hA5000002);

    // Core request raised during a 4-beat read burst
    h_req = 1; h_we = 0; h_addr = 12'h100; h_len = 4'd3; #1;
    chk("hr_gnt", 32'(h_gnt), 32'd1);
    exp_hb++;
    step(); h_req = 0; c_req = 1; c_we = 0; c_addr = 12'h010;
    for (int i = 1; i < 4; i++) begin
      #1;
      chk("stall_c_gnt", 32'(c_gnt), 32'd0);
      chk("stall_addr", 32'(mem_addr), 32'h100 + 32'(i));
      chk("stall_h_rvalid", 32'(h_rvalid), 32'd1);
      chk("stall_h_rdata", h_rdata, ref_mem[12'h100 + 12'(i - 1)]);
      exp_cw++; exp_hb++;
      step();
    end
    #1;
    chk("after_burst_c_gnt", 32'(c_gnt), 32'd1);
    chk("after_burst_h_rdata", h_rdata, ref_mem[12'h103]);
    chk("stat_core_wait_3", stat_core_wait, stat_exp(exp_cw));
    chk("stat_host_beats", stat_host_beats, stat_exp(exp_hb));
    step(); c_req = 0; #1;
    chk("after_burst_c_rdata", c_rdata, 32'hDEADBEEF);
    step();

    // Starvation limit with core request held
    c_req = 1; c_we = 0; c_addr = 12'h020;
    h_req = 1; h_we = 0; h_addr = 12'h200; h_len = 4'd1;
    for (int i = 0; i < WAIT_MAX; i++) begin
      #1;
      chk("starve_c_gnt", 32'(c_gnt), 32'd1);
      chk("starve_h_gnt", 32'(h_gnt), 32'd0);
      step();
    end
    #1;
    chk("starve_host_wins", 32'({h_gnt, c_gnt}), 32'b10);
    exp_cw++; exp_hb++;
    step(); h_req = 0; #1;
    chk("starve_beat1", 32'({h_beat, h_done, c_gnt}), 32'b110);
    exp_cw++; exp_hb++;
    step(); #1;
    chk("starve_core_back", 32'(c_gnt), 32'd1);
    step(); c_req = 0;

    // Single-beat host read
    h_req = 1; h_we = 0; h_addr = 12'h005; h_len = 4'd0; #1;
    chk("single_gnt_done", 32'({h_gnt, h_beat, h_done}), 32'b111);
    chk("single_addr", 32'(mem_addr), 32'h005);
    exp_hb++;
    step(); h_req = 0; #1;
    chk("single_rvalid", 32'(h_rvalid), 32'd1);
    chk("single_rdata", h_rdata, ref_mem[12'h005]);
    chk("single_back_idle", 32'(h_beat), 32'd0);
    chk("stat_host_beats2", stat_host_beats, stat_exp(exp_hb));
    step();

    // Reset during beat 2 of a 6-beat write
    h_req = 1; h_we = 1; h_addr = 12'h300; h_len = 4'd5;
    for (int i = 0; i < 2; i++) begin
      h_wdata = 32'hC0DE0000 + 32'(i); #1;
      chk("abort_beat", 32'(h_beat), 32'd1);
      ref_mem[12'h300 + 12'(i)] = h_wdata;
      step(); h_req = 0;
    end
    h_wdata = 32'hC0DE0002; reset = 1'b0;
    step(); reset = 1'b1; #1;
    exp_cw = 0; exp_hb = 0;
    chk_all_zero("abort");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_quiet", 32'({mem_we, h_beat, h_done}), 32'd0);
    end
    chk("abort_no_late_wr", 32'({env_wr[12'h303], env_wr[12'h304], env_wr[12'h305]}), 32'd0);
    c_req = 1; c_we = 0; c_addr = 12'h300; #1;
    chk("post_rst_c_gnt", 32'(c_gnt), 32'd1);
    step(); c_req = 0; #1;
    chk("post_rst_rdata", c_rdata, ref_mem[12'h300]);
    step();

    // Randomized traffic against a transaction-level model
    m_left = 0; m_wait = 0; m_addr = '0; m_we = 0; last_a = 12'h300;
    e_c_rv = 0; e_h_rv = 0; exp_c_rdata = ref_mem[12'h300]; exp_h_rdata = 32'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      chk("rnd_c_rvalid", 32'(c_rvalid), 32'(e_c_rv));
      chk("rnd_c_rdata", c_rdata, exp_c_rdata);
      chk("rnd_h_rvalid", 32'(h_rvalid), 32'(e_h_rv));
      chk("rnd_h_rdata", h_rdata, exp_h_rdata);
      chk("rnd_stat_cw", stat_core_wait, stat_exp(exp_cw));
      chk("rnd_stat_hb", stat_host_beats, stat_exp(exp_hb));
      c_req   = ($urandom_range(0, 99) < 60);
      c_we    = 1'($urandom);
      c_addr  = 12'($urandom_range(0, 31));
      c_wdata = $urandom;
      h_req   = ($urandom_range(0, 99) < 25);
      h_we    = 1'($urandom);
      h_addr  = 12'($urandom_range(0, 31)) - 12'd8;
      h_len   = 4'($urandom);
      h_wdata = $urandom;
      #1;
      ecg = 0; ehg = 0; ehb = 0; ehd = 0; ewe = 0; ea = last_a; ewd = 32'd0;
      if (m_left > 0) begin
        ehb = 1; ea = m_addr; ewe = m_we; ewd = h_wdata; ehd = (m_left == 1);
        m_left--; m_addr = m_addr + 12'd1;
      end else if (c_req && !(h_req && m_wait == WAIT_MAX)) begin
        ecg = 1; ea = c_addr; ewe = c_we; ewd = c_wdata;
        if (h_req && m_wait < WAIT_MAX) m_wait++;
      end else if (h_req) begin
        ehg = 1; ehb = 1; ea = h_addr; ewe = h_we; ewd = h_wdata; ehd = (h_len == 0);
        m_left = int'(h_len); m_addr = h_addr + 12'd1; m_we = h_we; m_wait = 0;
      end
      if (c_req && !ecg) exp_cw++;
      if (ehb) exp_hb++;
      chk("rnd_grants", 32'({c_gnt, h_gnt, h_beat, h_done}), 32'({ecg, ehg, ehb, ehd}));
      chk("rnd_mem_we", 32'(mem_we), 32'(ewe));
      chk("rnd_mem_addr", 32'(mem_addr), 32'(ea));
      if (ewe) chk("rnd_mem_wdata", mem_wdata, ewd);
      e_c_rv = ecg && !ewe;
      e_h_rv = ehb && !ewe;
      if (e_c_rv) exp_c_rdata = ref_mem[ea];
      if (e_h_rv) exp_h_rdata = ref_mem[ea];
      if (ewe) ref_mem[ea] = ewd;
      if (ecg || ehb) last_a = ea;
      step();
    end
    c_req = 0; h_req = 0;
    chk("final_stat_cw", stat_core_wait, stat_exp(exp_cw));
    chk("final_stat_hb", stat_host_beats, stat_exp(exp_hb));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
